// File: rtl/wb_rr_arbiter_pkg.sv
// Shared SoC bus definitions for the Wishbone round-robin arbiter.
// Master count, lane widths and arbiter state encodings.
package wb_rr_arbiter_pkg;

    localparam int NMST = 4;
    localparam int MW   = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int CTW  = 3;

    localparam logic [MW-1:0] GRANT_RST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_rr_arbiter_pick.sv
// Round-robin priority search over four requesters.
// Searches upward starting one past the last grantee.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt,
    output logic       any
);

    logic [1:0] idx;

    // Scan from farthest to nearest so the nearest requester wins
    always_comb begin
        gnt = last;
        idx = last;
        any = |req;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                gnt = idx;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Four-master Wishbone round-robin arbiter with stall watchdog.
// Slave port follows the grantee combinationally while BUSY.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NMST*AW-1:0]  m_adr_i,
    input  logic [NMST*DW-1:0]  m_dat_i,
    input  logic [NMST*SW-1:0]  m_sel_i,
    input  logic [NMST*CTW-1:0] m_cti_i,
    input  logic [NMST-1:0]     m_we_i,
    input  logic [NMST-1:0]     m_cyc_i,
    input  logic [NMST-1:0]     m_stb_i,
    output logic [DW-1:0]       m_dat_o,
    output logic [NMST-1:0]     m_ack_o,
    output logic [NMST-1:0]     m_err_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    output logic [SW-1:0]       s_sel_o,
    output logic [CTW-1:0]      s_cti_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    output logic [MW-1:0]       grant_o,
    output logic                timeout_o
);

    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_e    state_q;
    logic [MW-1:0] grant_q;
    logic [MW-1:0] pick_gnt;
    logic          pick_any;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          busy;
    logic          cyc_g;
    logic          stb_g;
    logic          stall;
    logic          to_hit;
    logic [3:0]    cti_lo;

    rr_pick4 u_pick (
        .req  (m_cyc_i),
        .last (grant_q),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    // Reset gates the bus immediately so nothing leaks mid-transaction
    assign busy   = sys_rst_n && (state_q == ST_BUSY);
    assign cyc_g  = m_cyc_i[grant_q];
    assign stb_g  = m_stb_i[grant_q];
    assign stall  = busy && stb_g && !s_ack_i;
    assign to_hit = (TIMEOUT != 0) && stall && cyc_g
                    && (cnt_q == TO_LAST);
    assign cti_lo = {2'b00, grant_q} * 4'd3;

    // Watchdog next value: saturating stall count, cleared by ack or exit
    always_comb begin
        cnt_d = cnt_q;
        if (!busy || !cyc_g || s_ack_i || to_hit) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Arbitration state machine: pick, hold for the cyc period, abort
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_RST;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_gnt;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!cyc_g) begin
                        state_q <= ST_IDLE;
                    end else if (to_hit) begin
                        state_q <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    if (!cyc_g) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Slave-side mux and per-master response routing
    always_comb begin
        s_adr_o   = m_adr_i[{grant_q, 5'd0} +: AW];
        s_dat_o   = m_dat_i[{grant_q, 5'd0} +: DW];
        s_sel_o   = m_sel_i[{grant_q, 2'd0} +: SW];
        s_cti_o   = m_cti_i[cti_lo +: CTW];
        s_we_o    = m_we_i[grant_q];
        s_cyc_o   = busy && cyc_g;
        s_stb_o   = busy && stb_g;
        m_dat_o   = s_dat_i;
        m_ack_o   = '0;
        m_err_o   = '0;
        timeout_o = to_hit;
        if (busy) begin
            m_ack_o[grant_q] = s_ack_i;
            m_err_o[grant_q] = to_hit;
        end
    end

    assign grant_o = grant_q;

endmodule
